instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Program-counter and instruction-register stage. It sits directly upstream of the control decoder. It drives the instruction-memory address and registers the returned word. It presents the 5-bit decode field to the control decoder. It resolves taken branches through an 8-entry target LUT and detects the halt encoding. It also owns the start/done run handshake for the core.

Parameters:
PCW, 10, program-counter width; instruction memory holds 2**PCW words.
IW, 9, instruction width.
LUTN, 8, branch-target LUT entries; index = IR[2:0].
HALT_OP, 9'h1FF, encoding that ends a program.

Ports:
Clk  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse to begin execution at PC 0.
stall  input  1  1 = hold PC, IR and instr_valid this cycle.
branch_taken  input  1  Branch from decoder ANDed with ALU zero; applies to the instruction currently in IR.
lut_we  input  1  branch-LUT write enable.
lut_idx  input  3  LUT write index.
lut_data  input  PCW  LUT write data (absolute target PC).
imem_data  input  IW  instruction memory read data; combinational from imem_addr.
imem_addr  output  PCW  current PC.
ir  output  IW  registered instruction.
ctrl_field  output  5  ir[IW-1:IW-5]; feeds the control decoder.
instr_valid  output  1  ir holds a live instruction; 0 = bubble, downstream must suppress RegWrite/MemWrite.
pc_of_ir  output  PCW  PC from which ir was fetched.
done  output  1  program halted; held until the next start.

Behaviour:
- States: IDLE, RUN, HALT. All regs reset asynchronously when Reset=0.
- Reset values: state=IDLE, PC=0, ir=0, pc_of_ir=0, instr_valid=0, done=0. All LUT entries=0.
- IDLE:
  - PC held at 0, instr_valid=0.
  - start=1 -> RUN next edge; PC=0, ir not loaded.
- RUN, stall=0, each edge:
  - ir<=imem_data, pc_of_ir<=PC, instr_valid<=1, PC<=PC+1.
  - Fetch latency: word at address A appears on ir exactly one edge after PC=A.
- Branch (RUN, stall=0, instr_valid=1, branch_taken=1):
  - PC<=LUT[ir[2:0]].
  - The sequentially fetched word is squashed: instr_valid<=0, ir<=0.
  - One bubble per taken branch.
  - Target word reaches ir two edges after the branch was in ir.
- branch_taken with instr_valid=0 is ignored.
- Halt (RUN, stall=0, instr_valid=1, ir==HALT_OP):
  - Next edge: state=HALT, done=1, instr_valid=0, PC frozen.
  - Halt takes priority over a simultaneous branch_taken.
- stall=1 in RUN: PC, ir, pc_of_ir, instr_valid, state all hold. branch_taken and halt detection are deferred until stall=0.
- HALT:
  - done=1, instr_valid=0.
  - start=1 -> RUN, PC=0, done<=0 on the same edge.
- start while in RUN is ignored.
- PC wrap: PC=2**PCW-1 with no branch -> PC=0 next edge. No error flag.
- LUT write is synchronous and occurs in any state. Write-then-read of the same entry in one cycle: the branch uses the old value; the new value is visible next edge.
- ctrl_field is purely combinational from ir. imem_addr is combinational from PC.
- Reset asserted mid-RUN: immediate return to reset values. LUT contents are cleared.

Test Plan:
- Reset, then start pulse; imem word at address k = k+9'h010 for k=0..5. Required: ir=9'h010,011,012 on successive edges; pc_of_ir=0,1,2; instr_valid=1 from the first fetch edge.
- LUT[3]=10'h040 written. Word at address 2 = 9'h023 with branch_taken=1 while it is in ir. Required: next edge instr_valid=0 and imem_addr=0x040; following edge pc_of_ir=0x040, instr_valid=1.
- stall=1 for 3 cycles while ir=9'h012. Required: ir, imem_addr and instr_valid unchanged all 3 cycles; fetching resumes with address 3 after release.
- ir=HALT_OP with branch_taken=1 in the same cycle. Required: done=1, instr_valid=0, PC frozen, no branch. Then a start pulse gives done=0 and imem_addr=0 on the next edge.
- Straight-line run from PC=0x3FF. Required: next imem_addr=0x000, pc_of_ir=0x3FF, instr_valid stays 1.
- Reset pulled low mid-RUN at PC=0x005. Required: all outputs return to reset values immediately, without waiting for a clock edge; the block stays in IDLE until start.

Source files
------------

// File: rtl/instr_fetch.sv
// Program-counter / instruction-register stage: fetches from instruction memory, resolves taken
// branches through a small target LUT, detects the halt word and owns the start/done handshake.
module instr_fetch #(
    parameter int unsigned   PCW     = 10,
    parameter int unsigned   IW      = 9,
    parameter int unsigned   LUTN    = 8,
    parameter logic [IW-1:0] HALT_OP = 9'h1FF
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    start,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic                    lut_we,
    input  logic [$clog2(LUTN)-1:0] lut_idx,
    input  logic [PCW-1:0]          lut_data,
    input  logic [IW-1:0]           imem_data,
    output logic [PCW-1:0]          imem_addr,
    output logic [IW-1:0]           ir,
    output logic [4:0]              ctrl_field,
    output logic                    instr_valid,
    output logic [PCW-1:0]          pc_of_ir,
    output logic                    done
);

    localparam int unsigned LIW = $clog2(LUTN);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [IW-1:0]  ir_q, ir_d;
    logic [PCW-1:0] poi_q, poi_d;
    logic           valid_q, valid_d;
    logic           done_q, done_d;
    logic [PCW-1:0] lut_q [LUTN];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        poi_d   = poi_q;
        valid_d = valid_q;
        done_d  = done_q;
        unique case (state_q)
            StIdle: begin
                pc_d    = '0;
                valid_d = 1'b0;
                done_d  = 1'b0;
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!stall) begin
                    // Halt wins over a branch resolved against the same instruction.
                    if (valid_q && (ir_q == HALT_OP)) begin
                        state_d = StHalt;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                    end else if (valid_q && branch_taken) begin
                        // Squash the sequentially fetched word; LUT read sees pre-write contents.
                        pc_d    = lut_q[ir_q[LIW-1:0]];
                        ir_d    = '0;
                        poi_d   = pc_q;
                        valid_d = 1'b0;
                    end else begin
                        ir_d    = imem_data;
                        poi_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 1'b1;
                    end
                end
            end
            StHalt: begin
                done_d  = 1'b1;
                valid_d = 1'b0;
                if (start) begin
                    state_d = StRun;
                    pc_d    = '0;
                    done_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
            poi_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            poi_q   <= poi_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < int'(LUTN); i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_we) begin
            lut_q[lut_idx] <= lut_data;
        end
    end

    assign imem_addr   = pc_q;
    assign ir          = ir_q;
    assign ctrl_field  = ir_q[IW-1:IW-5];
    assign instr_valid = valid_q;
    assign pc_of_ir    = poi_q;
    assign done        = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected per-edge observations are queued as stimulus is driven
// and popped against the DUT one time unit after each rising edge.
module tb_instr_fetch;

    localparam int unsigned PCW = 10;
    localparam int unsigned IW  = 9;

    logic           Clk = 1'b0;
    logic           Reset = 1'b0;
    logic           start = 1'b0;
    logic           stall = 1'b0;
    logic           branch_taken = 1'b0;
    logic           lut_we = 1'b0;
    logic [2:0]     lut_idx = '0;
    logic [PCW-1:0] lut_data = '0;
    logic [IW-1:0]  imem_data;
    logic [PCW-1:0] imem_addr;
    logic [IW-1:0]  ir;
    logic [4:0]     ctrl_field;
    logic           instr_valid;
    logic [PCW-1:0] pc_of_ir;
    logic           done;

    logic [IW-1:0] mem [0:1023];

    instr_fetch dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (start),
        .stall        (stall),
        .branch_taken (branch_taken),
        .lut_we       (lut_we),
        .lut_idx      (lut_idx),
        .lut_data     (lut_data),
        .imem_data    (imem_data),
        .imem_addr    (imem_addr),
        .ir           (ir),
        .ctrl_field   (ctrl_field),
        .instr_valid  (instr_valid),
        .pc_of_ir     (pc_of_ir),
        .done         (done)
    );

    assign imem_data = mem[imem_addr];

    always #5 Clk = ~Clk;

    typedef struct {
        string          tag;
        logic [PCW-1:0] addr;
        logic           valid;
        logic           done;
        bit             chk_ir;
        logic [IW-1:0]  ir;
        bit             chk_poi;
        logic [PCW-1:0] poi;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [PCW-1:0] addr, input logic valid,
                        input logic dn, input bit chk_ir, input logic [IW-1:0] exp_ir,
                        input bit chk_poi, input logic [PCW-1:0] poi);
        exp_t e;
        e.tag = tag; e.addr = addr; e.valid = valid; e.done = dn;
        e.chk_ir = chk_ir; e.ir = exp_ir; e.chk_poi = chk_poi; e.poi = poi;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        logic [IW-1:0] eir;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        cmp({e.tag, ".addr"}, 16'(imem_addr), 16'(e.addr));
        cmp({e.tag, ".valid"}, 16'(instr_valid), 16'(e.valid));
        cmp({e.tag, ".done"}, 16'(done), 16'(e.done));
        if (e.chk_ir) begin
            eir = e.ir;
            cmp({e.tag, ".ir"}, 16'(ir), 16'(eir));
            cmp({e.tag, ".ctrl"}, 16'(ctrl_field), 16'(eir[8:4]));
        end
        if (e.chk_poi) begin
            cmp({e.tag, ".pc_of_ir"}, 16'(pc_of_ir), 16'(e.poi));
        end
    endtask

    // Queue the expectation for the coming edge, clock it, then compare.
    task automatic step(input string tag, input logic [PCW-1:0] addr, input logic valid,
                        input logic dn, input bit chk_ir, input logic [IW-1:0] exp_ir,
                        input bit chk_poi, input logic [PCW-1:0] poi);
        push(tag, addr, valid, dn, chk_ir, exp_ir, chk_poi, poi);
        @(posedge Clk);
        #1;
        check_now();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int k = 0; k < 6; k++) mem[k] = 9'(9'h010 + k);

        // Reset values while Reset is held low.
        #2;
        push("reset", 10'h000, 1'b0, 1'b0, 1, 9'h000, 1, 10'h000);
        check_now();
        #1 Reset = 1'b1;

        // Straight-line fetch.
        start = 1'b1;
        step("start", 10'h000, 1'b0, 1'b0, 1, 9'h000, 1, 10'h000);
        start = 1'b0;
        step("fetch0", 10'h001, 1'b1, 1'b0, 1, 9'h010, 1, 10'h000);
        step("fetch1", 10'h002, 1'b1, 1'b0, 1, 9'h011, 1, 10'h001);
        step("fetch2", 10'h003, 1'b1, 1'b0, 1, 9'h012, 1, 10'h002);

        // Stall for three cycles with ir = 9'h012.
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step($sformatf("stall%0d", c), 10'h003, 1'b1, 1'b0, 1, 9'h012, 1, 10'h002);
        end
        stall = 1'b0;
        step("resume", 10'h004, 1'b1, 1'b0, 1, 9'h013, 1, 10'h003);
        step("fetch4", 10'h005, 1'b1, 1'b0, 1, 9'h014, 1, 10'h004);

        // Asynchronous reset mid-run at PC 5, checked before any edge.
        Reset = 1'b0;
        #1;
        push("async_rst", 10'h000, 1'b0, 1'b0, 1, 9'h000, 1, 10'h000);
        check_now();
        step("rst_held", 10'h000, 1'b0, 1'b0, 1, 9'h000, 1, 10'h000);
        Reset = 1'b1;
        step("idle0", 10'h000, 1'b0, 1'b0, 1, 9'h000, 1, 10'h000);
        step("idle1", 10'h000, 1'b0, 1'b0, 1, 9'h000, 1, 10'h000);

        // Branch program: LUT[3]=0x040, LUT[5]=0x3FF.
        mem[2]     = 9'h023;
        mem[10'h040] = 9'h0AA;
        mem[10'h041] = 9'h1FF;
        mem[10'h050] = 9'h0C5;
        mem[10'h3FF] = 9'h0DD;
        lut_we = 1'b1; lut_idx = 3'd3; lut_data = 10'h040;
        step("lut3", 10'h000, 1'b0, 1'b0, 1, 9'h000, 1, 10'h000);
        lut_idx = 3'd5; lut_data = 10'h3FF;
        step("lut5", 10'h000, 1'b0, 1'b0, 1, 9'h000, 1, 10'h000);
        lut_we = 1'b0;
        start = 1'b1;
        step("start2", 10'h000, 1'b0, 1'b0, 1, 9'h000, 0, 10'h000);
        start = 1'b0;
        step("b_f0", 10'h001, 1'b1, 1'b0, 1, 9'h010, 1, 10'h000);
        step("b_f1", 10'h002, 1'b1, 1'b0, 1, 9'h011, 1, 10'h001);
        step("b_f2", 10'h003, 1'b1, 1'b0, 1, 9'h023, 1, 10'h002);

        // Taken branch with a same-cycle rewrite of LUT[3]: old target must be used.
        branch_taken = 1'b1;
        lut_we = 1'b1; lut_idx = 3'd3; lut_data = 10'h050;
        step("branch", 10'h040, 1'b0, 1'b0, 1, 9'h000, 0, 10'h000);
        lut_we = 1'b0;
        // branch_taken still high over the bubble: must be ignored.
        step("target", 10'h041, 1'b1, 1'b0, 1, 9'h0AA, 1, 10'h040);
        branch_taken = 1'b0;
        step("halt_in", 10'h042, 1'b1, 1'b0, 1, 9'h1FF, 1, 10'h041);

        // Halt with simultaneous branch_taken.
        branch_taken = 1'b1;
        step("halt", 10'h042, 1'b0, 1'b1, 0, 9'h000, 0, 10'h000);
        step("halt_hold", 10'h042, 1'b0, 1'b1, 0, 9'h000, 0, 10'h000);
        branch_taken = 1'b0;
        start = 1'b1;
        step("restart", 10'h000, 1'b0, 1'b0, 0, 9'h000, 0, 10'h000);
        start = 1'b0;
        step("r_f0", 10'h001, 1'b1, 1'b0, 1, 9'h010, 1, 10'h000);
        start = 1'b1;
        step("start_in_run", 10'h002, 1'b1, 1'b0, 1, 9'h011, 1, 10'h001);
        start = 1'b0;
        step("r_f2", 10'h003, 1'b1, 1'b0, 1, 9'h023, 1, 10'h002);

        // Branch via updated LUT[3] to 0x050, then via LUT[5] to 0x3FF and wrap.
        branch_taken = 1'b1;
        step("branch2", 10'h050, 1'b0, 1'b0, 1, 9'h000, 0, 10'h000);
        branch_taken = 1'b0;
        step("target2", 10'h051, 1'b1, 1'b0, 1, 9'h0C5, 1, 10'h050);
        branch_taken = 1'b1;
        step("branch3", 10'h3FF, 1'b0, 1'b0, 1, 9'h000, 0, 10'h000);
        branch_taken = 1'b0;
        step("wrap", 10'h000, 1'b1, 1'b0, 1, 9'h0DD, 1, 10'h3FF);
        step("post_wrap", 10'h001, 1'b1, 1'b0, 1, 9'h010, 1, 10'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
